// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared constants and helpers for the mult_sat_array multiplier family.
//   SAT_CNT_W   : width of the per-channel saturation event counters
//   CALC_W      : working width for the scale/saturate arithmetic
//   shift_limit : largest useful right shift for a given pair of operand widths
//   sat_clip    : clip a signed value to a signed width, report if it clipped
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int SAT_CNT_W = 16;
  // Wide enough for any product plus a rounding carry at sane operand widths.
  localparam int CALC_W    = 64;

  // A product of two signed operands has in1_w+in2_w bits; shifting by more
  // than in1_w+in2_w-1 only replicates the sign bit, so that is the ceiling.
  function automatic int shift_limit(input int in1_w, input int in2_w);
    return in1_w + in2_w - 1;
  endfunction

  function automatic logic signed [CALC_W-1:0] sat_clip(
    input  logic signed [CALC_W-1:0] val,
    input  int                       width,
    output logic                     clipped
  );
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    clipped = 1'b0;
    if (val > hi) begin
      clipped = 1'b1;
      return hi;
    end
    if (val < lo) begin
      clipped = 1'b1;
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/mult_lane.sv
// -----------------------------------------------------------------------------
// mult_lane
// One channel of mult_sat_array: operand registers, signed product, scaling
// shift (optionally rounded when MULT_ROUND_EN is defined), saturation to
// OUTBITS, bypass of operand 1, output registers and saturation counter.
// The valid and shift pipeline is owned by the top level and arrives here
// already aligned with the S3 stage.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   sig1_i, sig2_i signed operands (raw, registered here in S1)
//   en_i           1 = multiply, 0 = bypass operand 1
//   vld_p1_i       valid of the sample currently in S3
//   shift_p1_i     clamped shift of the sample currently in S3
//   sat_clr_i      clears the saturation counter
//   signal_o       registered, saturated result
//   sat_o          result of the last valid sample was clipped
//   sat_cnt_o      saturating count of clipped valid samples
// -----------------------------------------------------------------------------
module mult_lane
  import mult_pkg::*;
#(
  parameter int INBITS1   = 14,
  parameter int INBITS2   = 14,
  parameter int OUTBITS   = 14,
  parameter int SHIFTBITS = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic signed [INBITS1-1:0]   sig1_i,
  input  logic signed [INBITS2-1:0]   sig2_i,
  input  logic                        en_i,
  input  logic                        vld_p1_i,
  input  logic        [SHIFTBITS-1:0] shift_p1_i,
  input  logic                        sat_clr_i,
  output logic signed [OUTBITS-1:0]   signal_o,
  output logic                        sat_o,
  output logic        [SAT_CNT_W-1:0] sat_cnt_o
);

  localparam int PW = INBITS1 + INBITS2;

  logic signed [INBITS1-1:0]   sig1_p0;
  logic signed [INBITS2-1:0]   sig2_p0;
  logic                        en_p0;
  logic signed [PW-1:0]        prod_p1;
  logic signed [INBITS1-1:0]   sig1_p1;
  logic                        en_p1;

  logic signed [CALC_W-1:0]    scaled;
  logic signed [CALC_W-1:0]    mul_val;
  logic signed [CALC_W-1:0]    byp_val;
  logic                        mul_clip;
  logic                        byp_clip;
  logic signed [OUTBITS-1:0]   signal_d;
  logic                        sat_d;
  logic signed [OUTBITS-1:0]   signal_q;
  logic                        sat_q;
  logic        [SAT_CNT_W-1:0] cnt_d;
  logic        [SAT_CNT_W-1:0] cnt_q;

`ifdef MULT_ROUND_EN
  // Round half up: add half an output LSB before the arithmetic shift.
  function automatic logic signed [CALC_W-1:0] round_half_up(
    input logic signed [CALC_W-1:0] v,
    input logic [SHIFTBITS-1:0]     sh
  );
    if (sh == '0) return v;
    return v + (64'sd1 <<< (sh - SHIFTBITS'(1)));
  endfunction
`endif

  // S1: operand registers
  always_ff @(posedge clk_i) begin
    sig1_p0 <= sig1_i;
    sig2_p0 <= sig2_i;
    en_p0   <= en_i;
  end

  // S2: full-width product; operand 1 follows for the bypass path
  always_ff @(posedge clk_i) begin
    prod_p1 <= PW'(sig1_p0) * PW'(sig2_p0);
    sig1_p1 <= sig1_p0;
    en_p1   <= en_p0;
  end

  // S3: scale, saturate, select
  always_comb begin
`ifdef MULT_ROUND_EN
    scaled = round_half_up(CALC_W'(prod_p1), shift_p1_i) >>> shift_p1_i;
`else
    scaled = CALC_W'(prod_p1) >>> shift_p1_i;
`endif
    mul_val = sat_clip(scaled, OUTBITS, mul_clip);
    byp_val = sat_clip(CALC_W'(sig1_p1), OUTBITS, byp_clip);
    if (en_p1) begin
      signal_d = OUTBITS'(mul_val);
      sat_d    = mul_clip;
    end else begin
      signal_d = OUTBITS'(byp_val);
      sat_d    = byp_clip;
    end
  end

  // Clear beats increment; the counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr_i) begin
      cnt_d = '0;
    end else if (vld_p1_i && sat_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + SAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      signal_q <= '0;
      sat_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (vld_p1_i) begin
        signal_q <= signal_d;
      end
      sat_q <= vld_p1_i & sat_d;
      cnt_q <= cnt_d;
    end
  end

  assign signal_o  = signal_q;
  assign sat_o     = sat_q;
  assign sat_cnt_o = cnt_q;

endmodule

// File: rtl/mult_sat_array.sv
// -----------------------------------------------------------------------------
// mult_sat_array
// NCH-channel signed multiplier with runtime arithmetic right shift,
// saturation to OUTBITS, per-channel bypass and saturation counters.
// Latency is 3 cycles for both multiply and bypass paths.
// Build option: define MULT_ROUND_EN to round half up before the shift;
// otherwise the shift truncates toward minus infinity.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   valid_i        input strobe shared by all channels
//   enable_i       per-channel multiply enable (0 = bypass operand 1)
//   signal1_i      operand 1, channel c at [c*INBITS1 +: INBITS1]
//   signal2_i      operand 2, channel c at [c*INBITS2 +: INBITS2]
//   shift_i        right-shift amount, clamped to INBITS1+INBITS2-1
//   sat_clr_i      clears all saturation counters
//   signal_o       results, channel c at [c*OUTBITS +: OUTBITS]
//   valid_o        result strobe
//   sat_o          per-channel clip flag for the current result
//   sat_cnt_o      per-channel 16-bit saturation counts
// -----------------------------------------------------------------------------
module mult_sat_array
  import mult_pkg::*;
#(
  parameter int INBITS1   = 14,
  parameter int INBITS2   = 14,
  parameter int OUTBITS   = 14,
  parameter int NCH       = 2,
  parameter int SHIFTBITS = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic [NCH-1:0]           enable_i,
  input  logic [NCH*INBITS1-1:0]   signal1_i,
  input  logic [NCH*INBITS2-1:0]   signal2_i,
  input  logic [SHIFTBITS-1:0]     shift_i,
  input  logic                     sat_clr_i,
  output logic [NCH*OUTBITS-1:0]   signal_o,
  output logic                     valid_o,
  output logic [NCH-1:0]           sat_o,
  output logic [NCH*SAT_CNT_W-1:0] sat_cnt_o
);

  localparam int SHIFT_MAX = shift_limit(INBITS1, INBITS2);

  logic [SHIFTBITS-1:0] shift_clamped;
  logic [SHIFTBITS-1:0] shift_p0;
  logic [SHIFTBITS-1:0] shift_p1;
  logic                 vld_p0;
  logic                 vld_p1;
  logic                 vld_p2;

  // If SHIFT_MAX does not fit in SHIFTBITS the compare never fires.
  always_comb begin
    shift_clamped = shift_i;
    if (int'(shift_i) > SHIFT_MAX) begin
      shift_clamped = SHIFTBITS'(SHIFT_MAX);
    end
  end

  // S1
  always_ff @(posedge clk_i) begin
    shift_p0 <= shift_clamped;
  end

  // S2
  always_ff @(posedge clk_i) begin
    shift_p1 <= shift_p0;
  end

  // Valid travels with the data through S1, S2 and the output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= valid_i;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  assign valid_o = vld_p2;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    mult_lane #(
      .INBITS1   (INBITS1),
      .INBITS2   (INBITS2),
      .OUTBITS   (OUTBITS),
      .SHIFTBITS (SHIFTBITS)
    ) u_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .sig1_i     (signal1_i[c*INBITS1 +: INBITS1]),
      .sig2_i     (signal2_i[c*INBITS2 +: INBITS2]),
      .en_i       (enable_i[c]),
      .vld_p1_i   (vld_p1),
      .shift_p1_i (shift_p1),
      .sat_clr_i  (sat_clr_i),
      .signal_o   (signal_o[c*OUTBITS +: OUTBITS]),
      .sat_o      (sat_o[c]),
      .sat_cnt_o  (sat_cnt_o[c*SAT_CNT_W +: SAT_CNT_W])
    );
  end

endmodule

// File: tb/tb_mult_sat_array.sv
// -----------------------------------------------------------------------------
// tb_mult_sat_array
// Directed, table-driven bench for mult_sat_array at default parameters.
// Expected values are hand-computed; entries that depend on rounding select
// their value with MULT_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_mult_sat_array;

`ifdef MULT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [1:0]  enable_i;
  logic [27:0] signal1_i;
  logic [27:0] signal2_i;
  logic [4:0]  shift_i;
  logic        sat_clr_i;
  logic [27:0] signal_o;
  logic        valid_o;
  logic [1:0]  sat_o;
  logic [31:0] sat_cnt_o;

  always #5 clk = ~clk;

  mult_sat_array dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .enable_i  (enable_i),
    .signal1_i (signal1_i),
    .signal2_i (signal2_i),
    .shift_i   (shift_i),
    .sat_clr_i (sat_clr_i),
    .signal_o  (signal_o),
    .valid_o   (valid_o),
    .sat_o     (sat_o),
    .sat_cnt_o (sat_cnt_o)
  );

  typedef struct {
    int         a1, b1, a2, b2;
    logic [1:0] en;
    int         sh;
    int         e0, e1;
    logic [1:0] es;
  } vec_t;

  localparam int NV = 10;
  vec_t tv[NV];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a1, input int b1, input int a2, input int b2,
                       input logic [1:0] e, input int s, input logic v);
    signal1_i = {14'(a2), 14'(a1)};
    signal2_i = {14'(b2), 14'(b1)};
    enable_i  = e;
    shift_i   = 5'(s);
    valid_i   = v;
  endtask

  function automatic logic signed [31:0] out_ch(input int c);
    logic [13:0] raw;
    raw = signal_o[c*14 +: 14];
    return 32'($signed(raw));
  endfunction

  function automatic logic signed [31:0] cnt_ch(input int c);
    return {16'h0, sat_cnt_o[c*16 +: 16]};
  endfunction

  int k;
  int exp_cnt0, exp_cnt1;

  initial begin
    tv[0] = '{4096, 4096, 100, 200, 2'b11, 13, 2048, 2, 2'b00};
    tv[1] = '{1, 4096, -1, 4096, 2'b11, 13, RND ? 1 : 0, RND ? 0 : -1, 2'b00};
    tv[2] = '{-8192, -8192, -5, 123, 2'b01, 13, 8191, -5, 2'b01};
    tv[3] = '{-8192, 8191, 3, 5, 2'b11, 12, -8192, 0, 2'b01};
    tv[4] = '{8191, 4096, -3000, 3000, 2'b11, 13, RND ? 4096 : 4095, -1099, 2'b00};
    tv[5] = '{8191, 4096, -3000, 3000, 2'b11, 12, 8191, RND ? -2197 : -2198, 2'b00};
    tv[6] = '{8191, 4096, -3000, 3000, 2'b11, 13, RND ? 4096 : 4095, -1099, 2'b00};
    tv[7] = '{-8192, -8192, -1, 1, 2'b11, 31, RND ? 1 : 0, RND ? 0 : -1, 2'b00};
    tv[8] = '{100, -50, 200, 200, 2'b11, 0, -5000, 8191, 2'b10};
    tv[9] = '{-8192, 0, 8191, 0, 2'b00, 13, -8192, 8191, 2'b00};

    rst_i = 1'b1;
    sat_clr_i = 1'b0;
    drive(-8192, -8192, -8192, -8192, 2'b11, 13, 1'b1);
    tick();
    tick();
    chk("reset valid_o", 32'(valid_o), 0);
    chk("reset signal_o", 32'(signal_o), 0);
    chk("reset sat_o", 32'(sat_o), 0);
    chk("reset sat_cnt_o", sat_cnt_o, 0);
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 2'b11, 13, 1'b0);
    tick();

    // Basic multiply with exact latency
    drive(4096, 4096, 0, 0, 2'b11, 13, 1'b1);
    tick();
    valid_i = 1'b0;
    chk("basic valid +1", 32'(valid_o), 0);
    tick();
    chk("basic valid +2", 32'(valid_o), 0);
    tick();
    chk("basic valid +3", 32'(valid_o), 1);
    chk("basic ch0", out_ch(0), 2048);
    chk("basic sat", 32'(sat_o), 0);
    tick();
    chk("basic valid +4", 32'(valid_o), 0);
    chk("basic hold ch0", out_ch(0), 2048);

    // Streamed table, one vector per cycle
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    for (int j = 0; j < NV + 2; j++) begin
      if (j < NV) drive(tv[j].a1, tv[j].b1, tv[j].a2, tv[j].b2, tv[j].en, tv[j].sh, 1'b1);
      else valid_i = 1'b0;
      tick();
      if (j >= 2) begin
        k = j - 2;
        chk($sformatf("vec%0d valid", k), 32'(valid_o), 1);
        chk($sformatf("vec%0d ch0", k), out_ch(0), tv[k].e0);
        chk($sformatf("vec%0d ch1", k), out_ch(1), tv[k].e1);
        chk($sformatf("vec%0d sat", k), 32'(sat_o), 32'(tv[k].es));
        exp_cnt0 += int'(tv[k].es[0]);
        exp_cnt1 += int'(tv[k].es[1]);
      end
    end
    chk("table cnt ch0", cnt_ch(0), exp_cnt0);
    chk("table cnt ch1", cnt_ch(1), exp_cnt1);

    // Saturation sequence from a fresh counter
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drive(-8192, -8192, 0, 0, 2'b11, 13, 1'b1);
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    chk("satpos ch0", out_ch(0), 8191);
    chk("satpos sat", 32'(sat_o), 1);
    chk("satpos cnt", cnt_ch(0), 1);
    drive(-8192, 8191, 0, 0, 2'b11, 12, 1'b1);
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    chk("satneg ch0", out_ch(0), -8192);
    chk("satneg sat", 32'(sat_o), 1);
    chk("satneg cnt", cnt_ch(0), 2);
    tick();
    chk("idle sat_o", 32'(sat_o), 0);
    chk("idle hold ch0", out_ch(0), -8192);

    // Clear coinciding with a saturating valid output
    drive(-8192, -8192, 0, 0, 2'b11, 13, 1'b1);
    tick();
    valid_i = 1'b0;
    tick();
    sat_clr_i = 1'b1;
    tick();
    sat_clr_i = 1'b0;
    chk("clr race sat", 32'(sat_o), 1);
    chk("clr race cnt", cnt_ch(0), 0);

    // Counter ceiling
    drive(-8192, -8192, 0, 0, 2'b11, 13, 1'b1);
    for (int j = 0; j < 70000; j++) tick();
    valid_i = 1'b0;
    tick();
    tick();
    tick();
    chk("cnt limit ch0", cnt_ch(0), 32'h0000FFFF);
    chk("cnt limit ch1", cnt_ch(1), 0);

    // Reset with three samples in flight
    drive(1000, 1000, 7, 7, 2'b11, 0, 1'b1);
    tick();
    drive(2000, 1, 8, 8, 2'b11, 0, 1'b1);
    tick();
    drive(3000, 1, 9, 9, 2'b11, 0, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    valid_i = 1'b0;
    chk("rst mid valid_o", 32'(valid_o), 0);
    chk("rst mid signal_o", 32'(signal_o), 0);
    chk("rst mid sat_o", 32'(sat_o), 0);
    chk("rst mid sat_cnt_o", sat_cnt_o, 0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("rst drain valid %0d", j), 32'(valid_o), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_sat_array.md
# mult_sat_array

Multi-channel signed multiplier with a registered pipeline, runtime-selectable output scaling, optional rounding, and output saturation. Each channel also has a per-channel saturation flag and a saturation event counter. It is the parametrised successor of the single-channel fixed-scale multiplier and sits in the DSP chain between signal sources (ADC, IQ demodulator, ASG) and downstream filters and DACs. Per-channel bypass passes operand 1 through with identical latency.

## Interface
- INBITS1, 14, operand-1 width per channel (signed)
- INBITS2, 14, operand-2 width per channel (signed)
- OUTBITS, 14, output width per channel (signed)
- NCH, 2, number of independent channels
- SHIFTBITS, 5, width of the runtime scale control
- clk_i  input  1  system clock; the block uses one clock only
- rst_i  input  1  synchronous active-high reset
- valid_i  input  1  input sample strobe, common to all channels
- enable_i  input  NCH  per-channel multiply enable; 0 selects bypass
- signal1_i  input  NCH*INBITS1  operand 1; channel c occupies bits [c*INBITS1 +: INBITS1]
- signal2_i  input  NCH*INBITS2  operand 2, packed the same way
- shift_i  input  SHIFTBITS  arithmetic right-shift applied to the product
- sat_clr_i  input  1  clears all saturation counters
- signal_o  output  NCH*OUTBITS  scaled, saturated result
- valid_o  output  1  result strobe
- sat_o  output  NCH  per-channel flag: the current result was clipped
- sat_cnt_o  output  NCH*16  per-channel count of saturation events

## Operation
- **S1.** Register signal1, signal2, enable, shift and valid.
  - shift is clamped to P = INBITS1+INBITS2-1 when it exceeds P.
- **S2.** Compute the full product, INBITS1+INBITS2 bits, signed.
  - enable, shift and valid travel alongside the data, so a change to shift_i or enable_i takes effect on exactly the sample it accompanies.
- **S3, multiply path.** Compute r = product >>> shift (arithmetic shift), then saturate r to OUTBITS:
  - r > 2^(OUTBITS-1)-1 gives 2^(OUTBITS-1)-1 and sets sat.
  - r < -2^(OUTBITS-1) gives -2^(OUTBITS-1) and sets sat.
- **S3, bypass path.** signal1 is saturated to OUTBITS by the same rule; sat is set if clipping occurs.
- **Default scale.** With the default widths, shift = 13 reproduces the legacy scaling.
- **Output registers.** signal_o and sat_o load only when the S3 valid is 1. When valid is 0, signal_o holds its value and sat_o is 0.
- **Saturation counter** (per channel, 16 bits). Priority, highest first:
  - sat_clr_i resets it to 0.
  - A valid output with sat set increments it.
  - It holds at 0xFFFF and does not wrap.
  - When sat_clr_i and an increment occur in the same cycle, the clear wins and the result is 0.

## Timing
- Latency is 3 cycles: valid_i in cycle n gives valid_o in cycle n+3.
- Throughput is 1 sample per cycle per channel; there is no backpressure.
- Multiply and bypass paths have identical latency.
- Reset values: signal_o = 0, valid_o = 0, sat_o = 0, sat_cnt_o = 0. All pipeline valid bits are also cleared.
- Reset mid-stream: all in-flight samples are discarded. The first valid_o after reset corresponds to a valid_i sampled 3 cycles after rst_i deasserts or later.

## Configuration
- **MULT_ROUND_EN defined:** before the shift, add 2^(shift-1) to the product when shift > 0 (round half up). Saturation is evaluated on the rounded value.
- **MULT_ROUND_EN undefined:** the shift truncates toward minus infinity and no adder is built.
- Latency is 3 cycles in both cases.

## Structure
- **Package mult_pkg:**
  - SAT_CNT_W = 16.
  - Saturation helper function taking a value and a width, returning the clipped value and a flag.
  - Shift clamp constant derivation.
- **Sub-module mult_lane:** one channel, comprising:
  - the S1–S3 data path,
  - bypass,
  - rounding,
  - saturation counter.
- **Top level:** generates NCH instances of mult_lane and shares the valid, shift and clear pipeline.

## Test plan
All values below use the default parameters.
- **Basic multiply:** ch0 4096 × 4096, shift 13, one valid_i pulse. Required: signal_o = 2048 and valid_o exactly 3 cycles later, sat_o = 0.
- **Rounding:** 1 × 4096, shift 13. Required: signal_o = 1 with MULT_ROUND_EN and 0 without it. Also -1 × 4096 gives 0 with the macro and -1 without it.
- **Saturation:**
  - -8192 × -8192, shift 13 gives 8191, sat_o[0] = 1, sat_cnt = 1.
  - -8192 × 8191, shift 12 gives -8192, sat_o[0] = 1, sat_cnt = 2.
- **Bypass and shift changes:**
  - enable_i = 2'b01 with ch1 signal1 = -5. Required: ch1 output = -5 with the same 3-cycle latency while ch0 multiplies.
  - Toggle shift_i 13 → 12 between consecutive samples. Required: each result uses its own shift.
- **Counter limits:**
  - Force 70000 saturating samples. Required: sat_cnt = 0xFFFF with no wrap.
  - Assert sat_clr_i together with a saturating valid output. Required: count = 0.
- **Reset mid-stream:** assert rst_i for 1 cycle with 3 samples in flight. Required: no valid_o for those samples, and all outputs are 0 the cycle after reset.
